// File: rtl/opll_write_scheduler.sv
// Write queue and access-spacing sequencer between the FM cartridge bus decode and the VM2413 core.
// Host writes land in a small FIFO and are replayed as timed cs_n/we_n strobes with enforced gaps.
module opll_write_scheduler #(
    parameter int FIFO_DEPTH   = 8,
    parameter int STROBE_TICKS = 6,
    parameter int ADDR_WAIT    = 72,
    parameter int DATA_WAIT    = 504,
    parameter int CNT_WIDTH    = 10
) (
    input  logic       RESET_n,
    input  logic       CLK,
    input  logic       CLK_EN,
    input  logic       FLUSH,
    input  logic       WR_REQ,
    input  logic       WR_A0,
    input  logic [7:0] WR_D,
    output logic       OPLL_CS_n,
    output logic       OPLL_WE_n,
    output logic       OPLL_A,
    output logic [7:0] OPLL_D,
    output logic       WAIT_n,
    output logic       BUSY,
    output logic       OVERFLOW
);
    localparam int PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_Q_W = $clog2(FIFO_DEPTH + 1);

    localparam logic [CNT_Q_W-1:0]   DEPTH_C     = CNT_Q_W'(FIFO_DEPTH);
    localparam logic [CNT_Q_W-1:0]   NEAR_FULL_C = CNT_Q_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] STROBE_LD   = CNT_WIDTH'(STROBE_TICKS - 1);
    localparam logic [CNT_WIDTH-1:0] ADDR_LD     = CNT_WIDTH'(ADDR_WAIT - 1);
    localparam logic [CNT_WIDTH-1:0] DATA_LD     = CNT_WIDTH'(DATA_WAIT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    logic [8:0]           mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_Q_W-1:0]   q_count;
    logic [CNT_Q_W-1:0]   q_count_next;
    logic [8:0]           head;
    logic                 pop;
    logic                 push_ok;
    logic                 drop;

    state_t               state;
    state_t               state_next;
    logic [CNT_WIDTH-1:0] tick_cnt;
    logic [CNT_WIDTH-1:0] tick_cnt_next;

    logic                 cs_n_next;
    logic                 a_next;
    logic [7:0]           d_next;
    logic                 wait_n_next;
    logic                 busy_next;

    // Pop only looks at the pre-edge count, so a fresh entry waits one edge before replay.
    assign head    = mem[rd_ptr];
    assign pop     = (state == IDLE) && CLK_EN && (q_count != '0);
    assign push_ok = WR_REQ && ((q_count != DEPTH_C) || pop);
    assign drop    = WR_REQ && !push_ok;

    always_comb begin
        q_count_next = q_count;
        if (push_ok && !pop)
            q_count_next = q_count + CNT_Q_W'(1);
        else if (pop && !push_ok)
            q_count_next = q_count - CNT_Q_W'(1);
    end

    always_ff @(posedge CLK) begin
        if (push_ok)
            mem[wr_ptr] <= {WR_A0, WR_D};
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            OVERFLOW <= 1'b0;
        end else if (FLUSH) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            q_count  <= '0;
            OVERFLOW <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            q_count <= q_count_next;
            if (drop)
                OVERFLOW <= 1'b1;
        end
    end

    // Sequencer state register; outputs are registered alongside it.
    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            OPLL_CS_n <= 1'b1;
            OPLL_WE_n <= 1'b1;
            OPLL_A    <= 1'b0;
            OPLL_D    <= 8'h00;
            WAIT_n    <= 1'b1;
            BUSY      <= 1'b0;
        end else if (FLUSH) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            OPLL_CS_n <= 1'b1;
            OPLL_WE_n <= 1'b1;
            OPLL_A    <= 1'b0;
            OPLL_D    <= 8'h00;
            WAIT_n    <= 1'b1;
            BUSY      <= 1'b0;
        end else begin
            state     <= state_next;
            tick_cnt  <= tick_cnt_next;
            OPLL_CS_n <= cs_n_next;
            OPLL_WE_n <= cs_n_next;
            OPLL_A    <= a_next;
            OPLL_D    <= d_next;
            WAIT_n    <= wait_n_next;
            BUSY      <= busy_next;
        end
    end

    // The gap length follows the port of the entry just strobed, still held on OPLL_A.
    always_comb begin
        state_next    = state;
        tick_cnt_next = tick_cnt;
        if (CLK_EN) begin
            unique case (state)
                IDLE: begin
                    if (q_count != '0) begin
                        state_next    = STROBE;
                        tick_cnt_next = STROBE_LD;
                    end
                end
                STROBE: begin
                    if (tick_cnt != '0) begin
                        tick_cnt_next = tick_cnt - CNT_WIDTH'(1);
                    end else begin
                        state_next    = GAP;
                        tick_cnt_next = OPLL_A ? DATA_LD : ADDR_LD;
                    end
                end
                GAP: begin
                    if (tick_cnt != '0)
                        tick_cnt_next = tick_cnt - CNT_WIDTH'(1);
                    else
                        state_next = IDLE;
                end
                default: begin
                    state_next    = IDLE;
                    tick_cnt_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        cs_n_next   = (state_next != STROBE);
        a_next      = pop ? head[8] : OPLL_A;
        d_next      = pop ? head[7:0] : OPLL_D;
        wait_n_next = (q_count_next < NEAR_FULL_C);
        busy_next   = (q_count_next != '0) || (state_next != IDLE);
    end

endmodule

// File: tb/tb_opll_write_scheduler.sv
// Scoreboard bench for opll_write_scheduler: queued writes must replay in order
// with the required strobe width and inter-access gaps.
`timescale 1ns/1ps
module tb_opll_write_scheduler;
    logic       RESET_n = 1'b0;
    logic       CLK     = 1'b0;
    logic       CLK_EN  = 1'b0;
    logic       FLUSH   = 1'b0;
    logic       WR_REQ  = 1'b0;
    logic       WR_A0   = 1'b0;
    logic [7:0] WR_D    = 8'h00;
    logic       OPLL_CS_n;
    logic       OPLL_WE_n;
    logic       OPLL_A;
    logic [7:0] OPLL_D;
    logic       WAIT_n;
    logic       BUSY;
    logic       OVERFLOW;

    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic [8:0] exp_q[$];
    int         starts[$];
    int         strobe_start = 0;
    int         last_rise    = 0;
    int         exp_len      = 6;
    logic       prev_cs      = 1'b1;
    logic [8:0] mon_e;
    int         p;
    int         fall;

    opll_write_scheduler dut (
        .RESET_n  (RESET_n),
        .CLK      (CLK),
        .CLK_EN   (CLK_EN),
        .FLUSH    (FLUSH),
        .WR_REQ   (WR_REQ),
        .WR_A0    (WR_A0),
        .WR_D     (WR_D),
        .OPLL_CS_n(OPLL_CS_n),
        .OPLL_WE_n(OPLL_WE_n),
        .OPLL_A   (OPLL_A),
        .OPLL_D   (OPLL_D),
        .WAIT_n   (WAIT_n),
        .BUSY     (BUSY),
        .OVERFLOW (OVERFLOW)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe monitor: each falling CS_n consumes one scoreboard entry.
    always @(negedge CLK) begin
        if (prev_cs && !OPLL_CS_n) begin
            strobe_start = cyc;
            starts.push_back(cyc);
            chk("we_at_start", int'(OPLL_WE_n), 0);
            if (exp_q.size() == 0) begin
                chk("spurious_strobe", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("strobe_a", int'(OPLL_A), int'(mon_e[8]));
                chk("strobe_d", int'(OPLL_D), int'(mon_e[7:0]));
            end
        end else if (!prev_cs && OPLL_CS_n) begin
            last_rise = cyc;
            chk("we_at_end", int'(OPLL_WE_n), 1);
            if (exp_len != 0)
                chk("strobe_len", cyc - strobe_start, exp_len);
        end
        prev_cs = OPLL_CS_n;
    end

    task automatic push(input logic a0, input logic [7:0] d, input bit accept);
        WR_REQ = 1'b1;
        WR_A0  = a0;
        WR_D   = d;
        if (accept)
            exp_q.push_back({a0, d});
        @(posedge CLK);
        #1;
        WR_REQ = 1'b0;
    endtask

    task automatic wait_idle(input int bound, output int fall_cyc);
        int n;
        n = 0;
        while (BUSY && n < bound) begin
            @(posedge CLK);
            #1;
            n++;
        end
        chk("idle_timeout", int'(BUSY), 0);
        fall_cyc = cyc;
    endtask

    initial begin
        // Reset values
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_cs_n", int'(OPLL_CS_n), 1);
        chk("rst_we_n", int'(OPLL_WE_n), 1);
        chk("rst_a", int'(OPLL_A), 0);
        chk("rst_d", int'(OPLL_D), 0);
        chk("rst_wait_n", int'(WAIT_n), 1);
        chk("rst_busy", int'(BUSY), 0);
        chk("rst_overflow", int'(OVERFLOW), 0);
        RESET_n = 1'b1;
        @(posedge CLK);
        #1;

        // Single address write
        CLK_EN = 1'b1;
        starts.delete();
        push(1'b0, 8'h10, 1);
        p = cyc;
        wait_idle(300, fall);
        chk("single_count", starts.size(), 1);
        chk("single_start", starts[0] - p, 1);
        chk("single_busy_fall", fall - p, 79);

        // Back-to-back address, data, address
        starts.delete();
        push(1'b0, 8'h10, 1);
        p = cyc;
        push(1'b1, 8'h21, 1);
        push(1'b0, 8'h33, 1);
        wait_idle(2000, fall);
        chk("b2b_count", starts.size(), 3);
        chk("b2b_first", starts[0] - p, 1);
        chk("b2b_addr_gap", starts[1] - starts[0], 79);
        chk("b2b_data_gap", starts[2] - starts[1], 511);

        // Overflow with the sequencer stalled
        CLK_EN = 1'b0;
        starts.delete();
        for (int i = 0; i < 9; i++) begin
            push(1'(i % 2), 8'hA0 + 8'(i), i < 8);
            if (i == 5) chk("wait_n_after6", int'(WAIT_n), 1);
            if (i == 6) chk("wait_n_after7", int'(WAIT_n), 0);
            if (i == 7) chk("ovf_after8", int'(OVERFLOW), 0);
            if (i == 8) chk("ovf_after9", int'(OVERFLOW), 1);
        end
        chk("gated_no_strobe", starts.size(), 0);
        CLK_EN = 1'b1;
        wait_idle(6000, fall);
        chk("ovf_replay_count", starts.size(), 8);
        chk("ovf_sticky", int'(OVERFLOW), 1);
        chk("ovf_wait_n_idle", int'(WAIT_n), 1);
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        chk("flush_clears_ovf", int'(OVERFLOW), 0);

        // Full queue, push on the pop edge
        CLK_EN = 1'b0;
        starts.delete();
        for (int i = 0; i < 8; i++)
            push(1'(i % 2), 8'hC0 + 8'(i), 1);
        CLK_EN = 1'b1;
        push(1'b1, 8'hE5, 1);
        chk("full_pop_push_ovf", int'(OVERFLOW), 0);
        chk("full_pop_push_wait_n", int'(WAIT_n), 0);
        wait_idle(8000, fall);
        chk("full_pop_push_count", starts.size(), 9);
        chk("full_pop_push_ovf_end", int'(OVERFLOW), 0);

        // CLK_EN active one cycle in six
        CLK_EN = 1'b0;
        starts.delete();
        push(1'b1, 8'h5A, 1);
        exp_len = 36;
        fall = 0;
        for (int i = 0; i < 4000 && fall == 0; i++) begin
            CLK_EN = (i % 6 == 0);
            @(posedge CLK);
            #1;
            if (!BUSY) fall = cyc;
        end
        CLK_EN = 1'b1;
        chk("gated_count", starts.size(), 1);
        chk("gated_gap", fall - last_rise, 3024);

        // FLUSH during a strobe with three entries still queued
        exp_len = 6;
        starts.delete();
        push(1'b0, 8'h01, 1);
        push(1'b1, 8'h02, 1);
        push(1'b0, 8'h03, 1);
        push(1'b1, 8'h04, 1);
        chk("pre_flush_cs_n", int'(OPLL_CS_n), 0);
        exp_len = 0;
        FLUSH = 1'b1;
        @(posedge CLK);
        #1;
        FLUSH = 1'b0;
        chk("flush_cs_n", int'(OPLL_CS_n), 1);
        chk("flush_we_n", int'(OPLL_WE_n), 1);
        chk("flush_busy", int'(BUSY), 0);
        chk("flush_wait_n", int'(WAIT_n), 1);
        chk("flush_ovf", int'(OVERFLOW), 0);
        exp_q.delete();
        repeat (2) @(posedge CLK);
        #1;
        starts.delete();
        exp_len = 6;
        repeat (700) @(posedge CLK);
        #1;
        chk("flush_no_strobe", starts.size(), 0);
        chk("flush_stays_idle", int'(BUSY), 0);
        push(1'b1, 8'h77, 1);
        p = cyc;
        wait_idle(1000, fall);
        chk("post_flush_count", starts.size(), 1);
        chk("post_flush_start", starts[0] - p, 1);
        chk("post_flush_busy_fall", fall - p, 511);

        chk("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
